// File: rtl/kart_pkg.sv
// Shared constants, scheduler state type and angle helpers for the kart
// velocity path.
package kart_pkg;

    localparam int ANGLE_W    = 9;
    localparam int TRIG_W     = 11;
    localparam int FRAC_SHIFT = 9;

    localparam logic [ANGLE_W-1:0]       ANGLE_MAX = ANGLE_W'(360);
    localparam logic [ANGLE_W-1:0]       ANGLE_QTR = ANGLE_W'(90);
    localparam logic signed [TRIG_W-1:0] TRIG_ONE  = TRIG_W'(512);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPUTE
    } sched_state_t;

    // Out-of-range headings are treated as 0 degrees.
    function automatic logic [ANGLE_W-1:0] clean_angle(
        input logic [ANGLE_W-1:0] d
    );
        return (d >= ANGLE_MAX) ? '0 : d;
    endfunction

    // sin(d) = cos(|d - 90|), so the cosine ROM serves both ports.
    function automatic logic [ANGLE_W-1:0] sin_angle(
        input logic [ANGLE_W-1:0] d
    );
        return (d > ANGLE_QTR) ? (d - ANGLE_QTR) : (ANGLE_QTR - d);
    endfunction

endpackage

// File: rtl/kart_vel_calc.sv
// Combinational velocity from speed and ROM trig words.
// Ports: speed, cos_val, sin_val in; vx, vy out (vy negated: screen y down).
module kart_vel_calc
    import kart_pkg::*;
#(
    parameter int SPEED_W = 4,
    parameter int VEL_W   = 12
) (
    input  logic [SPEED_W-1:0]       speed,
    input  logic signed [TRIG_W-1:0] cos_val,
    input  logic signed [TRIG_W-1:0] sin_val,
    output logic signed [VEL_W-1:0]  vx,
    output logic signed [VEL_W-1:0]  vy
);

    localparam int P = SPEED_W + TRIG_W + 1;
    localparam logic signed [P-1:0] BIAS =
        {{(P-FRAC_SHIFT){1'b0}}, {FRAC_SHIFT{1'b1}}};

    logic signed [P-1:0] spd_ext;
    logic signed [P-1:0] cos_ext;
    logic signed [P-1:0] sin_ext;
    logic signed [P-1:0] prod_x;
    logic signed [P-1:0] prod_y;
    logic signed [P-1:0] bias_x;
    logic signed [P-1:0] bias_y;
    logic signed [P-1:0] sum_x;
    logic signed [P-1:0] sum_y;
    logic signed [P-1:0] qx;
    logic signed [P-1:0] qy;

    assign spd_ext = $signed({{(TRIG_W+1){1'b0}}, speed});
    assign cos_ext = {{(SPEED_W+1){cos_val[TRIG_W-1]}}, cos_val};
    assign sin_ext = {{(SPEED_W+1){sin_val[TRIG_W-1]}}, sin_val};

    assign prod_x = spd_ext * cos_ext;
    assign prod_y = spd_ext * sin_ext;

    // Biasing negatives by 2^F-1 makes the arithmetic shift round to zero.
    assign bias_x = prod_x[P-1] ? BIAS : {P{1'b0}};
    assign bias_y = prod_y[P-1] ? BIAS : {P{1'b0}};
    assign sum_x  = prod_x + bias_x;
    assign sum_y  = prod_y + bias_y;
    assign qx     = sum_x >>> FRAC_SHIFT;
    assign qy     = sum_y >>> FRAC_SHIFT;

    assign vx = VEL_W'(qx);
    assign vy = VEL_W'(-qy);

endmodule

// File: rtl/kart_velocity_scheduler.sv
// Frame-triggered sequencer sharing one cos ROM across all karts.
// Ports: frame_start, kart_dir/speed, rom_* in/out; vel_x/y, busy, done,
// overrun out. OVERRUN_CNT_EN adds saturating overrun_count[7:0].
module kart_velocity_scheduler
    import kart_pkg::*;
#(
    parameter int NUM_KARTS   = 2,
    parameter int SPEED_W     = 4,
    parameter int VEL_W       = 12,
    parameter int ROM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [NUM_KARTS*ANGLE_W-1:0] kart_dir,
    input  logic [NUM_KARTS*SPEED_W-1:0] kart_speed,
    output logic [ANGLE_W-1:0]           rom_addr_cos,
    output logic [ANGLE_W-1:0]           rom_addr_sin,
    input  logic signed [TRIG_W-1:0]     rom_cos,
    input  logic signed [TRIG_W-1:0]     rom_sin,
    output logic [NUM_KARTS*VEL_W-1:0]   vel_x,
    output logic [NUM_KARTS*VEL_W-1:0]   vel_y,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0]                   overrun_count
`endif
);

    localparam int IDX_W = (NUM_KARTS > 1) ? $clog2(NUM_KARTS) : 1;
    localparam int WC_W  = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int LAST  = NUM_KARTS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(ROM_LATENCY - 1);

    sched_state_t state;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             nidx;
    logic [WC_W-1:0]              wcnt;
    logic [NUM_KARTS*ANGLE_W-1:0] dir_clean;
    logic [NUM_KARTS*ANGLE_W-1:0] dir_snap;
    logic [NUM_KARTS*SPEED_W-1:0] spd_snap;
    logic [NUM_KARTS*VEL_W-1:0]   shadow_x;
    logic [NUM_KARTS*VEL_W-1:0]   shadow_y;
    logic [ANGLE_W-1:0]           issue_dir;
    logic [SPEED_W-1:0]           cur_spd;
    logic signed [VEL_W-1:0]      vx;
    logic signed [VEL_W-1:0]      vy;

    always_comb begin
        dir_clean = '0;
        for (int k = 0; k < NUM_KARTS; k++) begin
            dir_clean[k*ANGLE_W +: ANGLE_W] =
                clean_angle(kart_dir[k*ANGLE_W +: ANGLE_W]);
        end
    end

    // Address for the next ISSUE: kart 0 from the live inputs on start,
    // otherwise the following kart from the snapshot.
    always_comb begin
        nidx      = idx + 1'b1;
        issue_dir = (state == IDLE) ? dir_clean[0 +: ANGLE_W]
                                    : dir_snap[nidx*ANGLE_W +: ANGLE_W];
    end

    assign cur_spd = spd_snap[idx*SPEED_W +: SPEED_W];

    kart_vel_calc #(
        .SPEED_W (SPEED_W),
        .VEL_W   (VEL_W)
    ) u_calc (
        .speed   (cur_spd),
        .cos_val (rom_cos),
        .sin_val (rom_sin),
        .vx      (vx),
        .vy      (vy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            wcnt         <= '0;
            dir_snap     <= '0;
            spd_snap     <= '0;
            shadow_x     <= '0;
            shadow_y     <= '0;
            vel_x        <= '0;
            vel_y        <= '0;
            rom_addr_cos <= '0;
            rom_addr_sin <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= frame_start && busy;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        dir_snap     <= dir_clean;
                        spd_snap     <= kart_speed;
                        idx          <= '0;
                        busy         <= 1'b1;
                        rom_addr_cos <= issue_dir;
                        rom_addr_sin <= sin_angle(issue_dir);
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= WC_W'(1);
                    state <= (ROM_LATENCY > 1) ? WAIT : COMPUTE;
                end
                WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        state <= COMPUTE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (idx == LAST_IDX) begin
                        vel_x <= shadow_x;
                        vel_y <= shadow_y;
                        vel_x[LAST*VEL_W +: VEL_W] <= vx;
                        vel_y[LAST*VEL_W +: VEL_W] <= vy;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        shadow_x[idx*VEL_W +: VEL_W] <= vx;
                        shadow_y[idx*VEL_W +: VEL_W] <= vy;
                        idx          <= nidx;
                        rom_addr_cos <= issue_dir;
                        rom_addr_sin <= sin_angle(issue_dir);
                        state        <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_count <= '0;
        end else if (overrun && overrun_count != 8'hFF) begin
            overrun_count <= overrun_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kart_velocity_scheduler.sv
// Directed bench for kart_velocity_scheduler with a 2-cycle cos ROM model.
// Inputs change and outputs are sampled on the falling edge.
module tb_kart_velocity_scheduler;
    import kart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [17:0] kart_dir;
    logic [7:0]  kart_speed;
    logic [8:0]  rom_addr_cos;
    logic [8:0]  rom_addr_sin;
    logic signed [10:0] rom_cos;
    logic signed [10:0] rom_sin;
    logic signed [10:0] cos_p1;
    logic signed [10:0] sin_p1;
    logic [23:0] vel_x;
    logic [23:0] vel_y;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef OVERRUN_CNT_EN
    logic [7:0]  overrun_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kart_velocity_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .kart_dir     (kart_dir),
        .kart_speed   (kart_speed),
        .rom_addr_cos (rom_addr_cos),
        .rom_addr_sin (rom_addr_sin),
        .rom_cos      (rom_cos),
        .rom_sin      (rom_sin),
        .vel_x        (vel_x),
        .vel_y        (vel_y),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
`ifdef OVERRUN_CNT_EN
        ,
        .overrun_count(overrun_count)
`endif
    );

    function automatic logic signed [10:0] cos_tab(input logic [8:0] a);
        case (a)
            9'd0:    return TRIG_ONE;
            9'd45:   return 11'sd362;
            9'd90:   return 11'sd0;
            9'd135:  return -11'sd362;
            9'd180:  return -11'sd512;
            9'd225:  return -11'sd362;
            default: return 11'sd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cos_p1  <= cos_tab(rom_addr_cos);
        sin_p1  <= cos_tab(rom_addr_sin);
        rom_cos <= cos_p1;
        rom_sin <= sin_p1;
    end

    function automatic logic [23:0] pk(input int k0, input int k1);
        return {12'(k1), 12'(k0)};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        n_cmp++; if (vel_x !== 24'd0) begin n_bad++; $display("FAIL rst_vel_x got %h want 0", vel_x); end
        n_cmp++; if (vel_y !== 24'd0) begin n_bad++; $display("FAIL rst_vel_y got %h want 0", vel_y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
        n_cmp++; if (rom_addr_cos !== 9'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", rom_addr_cos); end
    endtask

    task automatic test_basic;
        kart_dir = {9'd90, 9'd0};
        kart_speed = {4'd6, 4'd6};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_cmp++; if (rom_addr_cos !== 9'd0) begin n_bad++; $display("FAIL basic_c1_cos got %0d want 0", rom_addr_cos); end
        n_cmp++; if (rom_addr_sin !== 9'd90) begin n_bad++; $display("FAIL basic_c1_sin got %0d want 90", rom_addr_sin); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_c1_busy got %b want 1", busy); end
        for (int c = 2; c <= 6; c++) begin
            tick(1);
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done c%0d got %b want 0", c, done); end
            n_cmp++; if (vel_x !== 24'd0) begin n_bad++; $display("FAIL basic_partial c%0d got %h want 0", c, vel_x); end
            if (c == 4) begin
                n_cmp++; if (rom_addr_cos !== 9'd90) begin n_bad++; $display("FAIL basic_c4_cos got %0d want 90", rom_addr_cos); end
                n_cmp++; if (rom_addr_sin !== 9'd0) begin n_bad++; $display("FAIL basic_c4_sin got %0d want 0", rom_addr_sin); end
            end
        end
        tick(1);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_c7_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_c7_busy got %b want 0", busy); end
        n_cmp++; if (vel_x !== pk(6, 0)) begin n_bad++; $display("FAIL basic_vel_x got %h want %h", vel_x, pk(6, 0)); end
        n_cmp++; if (vel_y !== pk(0, -6)) begin n_bad++; $display("FAIL basic_vel_y got %h want %h", vel_y, pk(0, -6)); end
        tick(1);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_c8_done got %b want 0", done); end
        tick(2);
    endtask

    task automatic test_rounding;
        kart_dir = {9'd225, 9'd45};
        kart_speed = {4'd6, 4'd6};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(5);
        n_cmp++; if (vel_x !== pk(6, 0)) begin n_bad++; $display("FAIL round_hold got %h want %h", vel_x, pk(6, 0)); end
        tick(1);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL round_done got %b want 1", done); end
        n_cmp++; if (vel_x !== pk(4, -4)) begin n_bad++; $display("FAIL round_vel_x got %h want %h", vel_x, pk(4, -4)); end
        n_cmp++; if (vel_y !== pk(-4, 4)) begin n_bad++; $display("FAIL round_vel_y got %h want %h", vel_y, pk(-4, 4)); end
        tick(2);
    endtask

    task automatic test_overrun;
        kart_dir = {9'd90, 9'd0};
        kart_speed = {4'd6, 4'd6};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
        kart_dir = {9'd180, 9'd0};
        tick(1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_c4 got %b want 1", overrun); end
        n_cmp++; if (rom_addr_cos !== 9'd90) begin n_bad++; $display("FAIL ovr_snap_addr got %0d want 90", rom_addr_cos); end
`ifdef OVERRUN_CNT_EN
        tick(1);
        n_cmp++; if (overrun_count !== 8'd1) begin n_bad++; $display("FAIL ovr_count got %0d want 1", overrun_count); end
`else
        tick(1);
`endif
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_c5 got %b want 0", overrun); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ovr_c5_done got %b want 0", done); end
        tick(1);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ovr_c6_done got %b want 0", done); end
        tick(1);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ovr_c7_done got %b want 1", done); end
        n_cmp++; if (vel_x !== pk(6, 0)) begin n_bad++; $display("FAIL ovr_vel_x got %h want %h", vel_x, pk(6, 0)); end
        n_cmp++; if (vel_y !== pk(0, -6)) begin n_bad++; $display("FAIL ovr_vel_y got %h want %h", vel_y, pk(0, -6)); end
        kart_dir = {9'd90, 9'd0};
        tick(2);
    endtask

    task automatic test_done_edge;
        kart_dir = {9'd225, 9'd45};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(5);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL edge_done got %b want 1", done); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL edge_overrun got %b want 1", overrun); end
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL edge_busy got %b want 0", busy); end
`ifdef OVERRUN_CNT_EN
        n_cmp++; if (overrun_count !== 8'd2) begin n_bad++; $display("FAIL edge_count got %0d want 2", overrun_count); end
`endif
        tick(2);
    endtask

    task automatic test_bad_dir;
        kart_dir = {9'd45, 9'd400};
        kart_speed = {4'd0, 4'd6};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_cmp++; if (rom_addr_cos !== 9'd0) begin n_bad++; $display("FAIL bad_dir_cos got %0d want 0", rom_addr_cos); end
        n_cmp++; if (rom_addr_sin !== 9'd90) begin n_bad++; $display("FAIL bad_dir_sin got %0d want 90", rom_addr_sin); end
        tick(6);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bad_dir_done got %b want 1", done); end
        n_cmp++; if (vel_x !== pk(6, 0)) begin n_bad++; $display("FAIL bad_dir_vel_x got %h want %h", vel_x, pk(6, 0)); end
        n_cmp++; if (vel_y !== pk(0, 0)) begin n_bad++; $display("FAIL bad_dir_vel_y got %h want %h", vel_y, pk(0, 0)); end
        tick(2);
    endtask

    task automatic test_reset_midrun;
        kart_dir = {9'd90, 9'd0};
        kart_speed = {4'd6, 4'd6};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_cmp++; if (vel_x !== 24'd0) begin n_bad++; $display("FAIL mid_rst_vel_x got %h want 0", vel_x); end
        n_cmp++; if (vel_y !== 24'd0) begin n_bad++; $display("FAIL mid_rst_vel_y got %h want 0", vel_y); end
        for (int c = 5; c <= 9; c++) begin
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done c%0d got %b want 0", c, done); end
            tick(1);
        end
        kart_dir = {9'd225, 9'd45};
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int c = 11; c <= 16; c++) begin
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_new_done c%0d got %b want 0", c, done); end
            tick(1);
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mid_c17_done got %b want 1", done); end
        n_cmp++; if (vel_x !== pk(4, -4)) begin n_bad++; $display("FAIL mid_vel_x got %h want %h", vel_x, pk(4, -4)); end
        n_cmp++; if (vel_y !== pk(-4, 4)) begin n_bad++; $display("FAIL mid_vel_y got %h want %h", vel_y, pk(-4, 4)); end
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        kart_dir = '0;
        kart_speed = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_rounding;
        test_overrun;
        test_done_edge;
        test_bad_dir;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kart_velocity_scheduler.md
Name: kart_velocity_scheduler

Overview:
Once per frame, computes per-kart velocity vectors (vx, vy) from each kart's heading and speed. All karts share a single dual-port cosine ROM (port A gives cos, port B gives sin via an angle transform). The block sits between the kart state registers and the position-update logic. It replaces ad-hoc hcount/vcount-timed lookups with a frame_start-triggered sequencer and a busy/done handshake.

Parameters:
NUM_KARTS, 2, number of karts serviced per frame
ANGLE_W, 9, heading width in degrees (0..359 valid)
TRIG_W, 11, signed ROM word; 512 represents 1.0
SPEED_W, 4, unsigned speed per kart
VEL_W, 12, signed velocity output width
ROM_LATENCY, 2, cycles from address presented to ROM data valid (HIGH_PERFORMANCE RAM)
FRAC_SHIFT, 9, divisor exponent (divide by 512)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk
frame_start  in  1  single-cycle pulse that starts a scheduling run
kart_dir  in  NUM_KARTS*ANGLE_W  packed headings; kart k at bits [k*ANGLE_W +: ANGLE_W]
kart_speed  in  NUM_KARTS*SPEED_W  packed speeds
rom_addr_cos  out  ANGLE_W  ROM port A address
rom_addr_sin  out  ANGLE_W  ROM port B address
rom_cos  in  TRIG_W  signed port A data
rom_sin  in  TRIG_W  signed port B data
vel_x  out  NUM_KARTS*VEL_W  signed packed x velocities
vel_y  out  NUM_KARTS*VEL_W  signed packed y velocities (screen y increases downward)
busy  out  1  run in progress
done  out  1  one-cycle pulse; vel_x/vel_y hold new values from this cycle
overrun  out  1  one-cycle pulse; frame_start was ignored because busy was high

Behaviour:
- Reset values: all outputs 0; FSM goes to IDLE; snapshot and shadow registers are cleared.
- FSM states: IDLE, ISSUE, WAIT, COMPUTE.
- IDLE, frame_start=1:
  - Snapshot all kart_dir and kart_speed values. Any dir >= 360 is replaced by 0.
  - Set idx=0, busy=1, next state ISSUE.
- ISSUE:
  - rom_addr_cos = dir[idx].
  - rom_addr_sin = (dir>90) ? dir-90 : 90-dir.
  - Both addresses are registered and held until the next ISSUE (they also hold while IDLE).
  - Next state WAIT.
- WAIT: stay for ROM_LATENCY-1 cycles, then go to COMPUTE.
- COMPUTE (ROM_LATENCY cycles after ISSUE):
  - vx = (speed*rom_cos)/2^FRAC_SHIFT.
  - vy = -(speed*rom_sin)/2^FRAC_SHIFT.
  - Products are signed, SPEED_W+TRIG_W+1 bits wide; division truncates toward zero, then the result is sign-truncated to VEL_W.
  - Results for karts before the last go to shadow registers, then idx++ and next state ISSUE.
  - On the last kart: commit every shadow plus the current result to vel_x/vel_y in the same edge, pulse done, drop busy, return to IDLE.
- Timing: frame_start in cycle 0 → ISSUE for kart k in cycle 1+k(L+1). Outputs update, done=1 and busy=0 in cycle 1+N(L+1), where L=ROM_LATENCY and N=NUM_KARTS. With the defaults this is cycle 7.
- vel outputs never show a partial frame; they change only on the done edge.
- frame_start while busy is ignored, and overrun pulses on the next cycle. frame_start in the same cycle as done's edge counts as busy.
- kart_dir/kart_speed changes mid-run have no effect on the current run.
- rst mid-run aborts: vel outputs return to 0 and done is not pulsed.
- speed=0 gives vx=vy=0.

Optional Feature:
OVERRUN_CNT_EN: adds output port overrun_count [7:0]. It increments on every overrun pulse, saturates at 255 and clears on rst. Without the macro the port and counter are absent; only the overrun pulse exists.

Decomposition:
- Package kart_pkg holds:
  - ANGLE_W, TRIG_W, FRAC_SHIFT
  - ANGLE_MAX=360, TRIG_ONE=512
  - the sched_state_t enum (IDLE, ISSUE, WAIT, COMPUTE)
- Sub-module kart_vel_calc: combinational. Takes speed, cos, sin and returns vx, vy with the truncate-toward-zero divide. It is shared with future physics blocks.

Test Plan:
- Reset, then idle 20 cycles → vel_x/vel_y=0, busy=0, done=0, overrun=0.
- Defaults. Kart0 dir=0 spd=6, kart1 dir=90 spd=6, frame_start at cycle 0.
  - Cycle 1: rom_addr_cos=0, rom_addr_sin=90.
  - Cycle 7: done=1, vel_x0=6, vel_y0=0, vel_x1=0, vel_y1=-6.
- Rounding with cos45=362. Kart0 dir=45 spd=6 → vx=4, vy=-4. Kart1 dir=225 spd=6 → vx=-4, vy=+4 (not -5/+5).
- frame_start again at cycle 3 → overrun=1 in cycle 4; done still only at cycle 7. Under OVERRUN_CNT_EN, overrun_count=1.
- Kart1 dir changes 90→180 at cycle 2 → cycle-7 results still match dir=90. dir=400 in the snapshot → treated as 0 (vx=6 at spd=6).
- rst at cycle 4 → cycle 5: busy=0, vel=0, no done pulse. A new frame_start at cycle 10 → done at cycle 17 with correct values.
